jogador_automatico: RTL and testbench
=====================================

Name: jogador_automatico

Overview:
- Hardware auto-player for the jogo_desafio_memoria game; sits on the other end of the leds/botoes interface.
- Watches the LED sequence the game shows, stores it, and replays it on botoes with debounce-safe timing.
- In every round except the last, it then adds the next jogada to the sequence.
- Used for on-board self-test and demo mode; drives jogar/configuracao itself and reports the outcome.

Parameters:
- N_RODADAS, 16, number of rounds needed to win (1..16).
- T_PRESS, 5, clock cycles a button is held.
- T_SOLTA, 5, clock cycles of release after each press.
- T_GAP, 4, cycles to wait after the last LED turns off before the first press.
- WATCHDOG, 4096, maximum cycles without progress (LED edge or ganhou) before abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- iniciar  in  1  start pulse; sampled only in OCIOSO.
- modo  in  2  game mode; latched on start and driven on configuracao.
- leds  in  4  game LED outputs, one-hot while lit.
- ganhou  in  1  game win flag.
- perdeu  in  1  game loss flag.
- timeout  in  1  game timeout flag.
- jogar  out  1  start request to the game.
- configuracao  out  2  latched modo.
- botoes  out  4  one-hot button drive.
- rodada  out  5  current round, 0-based.
- concluido  out  1  high in either final state.
- sucesso  out  1  high in FIM_SUCESSO.
- falha  out  1  high in FIM_FALHA.
- db_divergencia  out  1  sticky: a captured LED differed from the jogada this block added.
- db_estado  out  5  FSM state code.

Behaviour:
- Reset values: all outputs 0. Memory contents are don't-care.
- Storage: 16x4 register file mem. Index counter idx is 4 bits. Pulse counter cnt is 5 bits. Timer is sized for max(T_*, WATCHDOG).
- LED edge: a registered flag aceso = (leds != 0).
  - Rising edge = aceso goes 0->1 while in OBSERVA.
  - On a rising edge, write mem[cnt] <= leds (captured on the same cycle) and increment cnt.
- Addition pattern: the jogada added at index i (i >= 1) is 4'b0001 << (i mod 4).
  - When an LED is captured at index i >= 1 and i == rodada, compare it with that pattern.
  - On mismatch, set db_divergencia. It clears only on reset or a new start.
- FSM states with 5-bit codes:
  - OCIOSO 0: waits for iniciar. On iniciar: configuracao <= modo; rodada, cnt, idx, db_divergencia <= 0; go to INICIA.
  - INICIA 1: jogar = 1 for exactly 2 cycles, then go to OBSERVA.
  - OBSERVA 2: capture LED edges. When cnt == rodada+1 and aceso == 0, go to GAP.
  - GAP 3: wait T_GAP cycles, set idx <= 0, go to PRESSIONA.
  - PRESSIONA 4: botoes = mem[idx] for T_PRESS cycles, then go to SOLTA.
  - SOLTA 5: botoes = 0 for T_SOLTA cycles. Then:
    - if idx < rodada: idx++ and go to PRESSIONA;
    - else if rodada == N_RODADAS-1: go to AGUARDA_FIM;
    - else go to ADICIONA.
  - ADICIONA 6: botoes = pattern(rodada+1) for T_PRESS cycles, then go to ADICIONA_SOLTA.
  - ADICIONA_SOLTA 7: botoes = 0 for T_SOLTA cycles. Then rodada++, cnt <= 0, go to OBSERVA.
  - AGUARDA_FIM 8: wait for ganhou.
  - FIM_SUCESSO 9: terminal.
  - FIM_FALHA 10: terminal.
- Global priority, checked every cycle in any non-final state other than OCIOSO:
  - perdeu or timeout -> FIM_FALHA. This wins over every other event, including ganhou in the same cycle.
  - Otherwise ganhou -> FIM_SUCESSO.
- Watchdog: the timer restarts on every state change and every LED rising edge. If it reaches WATCHDOG in OBSERVA or AGUARDA_FIM -> FIM_FALHA.
- Final states: botoes = 0, jogar = 0. iniciar returns to OCIOSO; the start is taken on the next iniciar.
- Extra LED edge in OBSERVA beyond rodada+1 pulses: ignored, mem is not written. cnt saturates at rodada+1.
- A non-one-hot leds value is stored as-is and replayed unchanged.
- Asynchronous reset mid-game: immediate return to OCIOSO with all outputs 0. botoes drop the same instant.
- botoes is registered. It never carries more than one bit set unless a corrupt LED value was captured.

Decomposition:
- Package jogador_pkg:
  - state codes (11 states, 5 bits);
  - function pattern(i) returning 4'b0001 << (i mod 4);
  - widths IDX_W = 4 and CNT_W = 5.
- Sub-module contador_timer (load value, enable, done flag), instanced once and shared by all timed states and the watchdog.

Test Plan:
- Behavioural game model, modo=00, N_RODADAS=16, first jogada 0001 -> 136 replay presses plus 15 additions, the addition at index i equal to 0001<<(i mod 4); ganhou seen -> sucesso=1, concluido=1, db_divergencia=0.
- Model injects a wrong LED at index 3 (0001 instead of 1000) in round 3 -> db_divergencia=1; the block replays 0001; the model raises perdeu -> falha=1 within 1 cycle.
- timeout asserted while in PRESSIONA at round 5 -> next state FIM_FALHA, botoes=0 on the following edge.
- Game stalls with no LED for WATCHDOG cycles in OBSERVA -> falha=1, db_estado=10.
- Reset pulse of 40 ns during ADICIONA -> botoes=0 and jogar=0 immediately; db_estado=0; a new iniciar restarts at rodada=0 with jogar high for 2 cycles.
- N_RODADAS=1 -> 1 LED observed, 1 press, no addition, AGUARDA_FIM; ganhou together with perdeu in the same cycle -> FIM_FALHA.

Source files
------------

// File: rtl/jogador_pkg.sv
// Shared definitions for the jogo_desafio_memoria auto-player: state codes,
// storage widths and the jogada pattern the player adds each round.
package jogador_pkg;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned LED_W = 4;
   localparam int unsigned MEM_D = 16;

   typedef enum logic [4:0] {
      OCIOSO         = 5'd0,
      INICIA         = 5'd1,
      OBSERVA        = 5'd2,
      GAP            = 5'd3,
      PRESSIONA      = 5'd4,
      SOLTA          = 5'd5,
      ADICIONA       = 5'd6,
      ADICIONA_SOLTA = 5'd7,
      AGUARDA_FIM    = 5'd8,
      FIM_SUCESSO    = 5'd9,
      FIM_FALHA      = 5'd10
   } estado_t;

   // Jogada added at index i: one-hot walking through the four buttons.
   function automatic logic [LED_W-1:0] pattern(input logic [CNT_W-1:0] i);
      return 4'b0001 << (i % CNT_W'(4));
   endfunction

endpackage

// File: rtl/jogador_automatico_timer.sv
// Loadable down-counter shared by every timed state and the watchdog;
// done_c is high while the count sits at zero.
module contador_timer #(
   parameter int unsigned W = 13
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_c = (cnt_q == '0);

endmodule

// File: rtl/jogador_automatico.sv
// Auto-player for jogo_desafio_memoria: captures the LED sequence, replays it
// on botoes, appends the next jogada each round and reports the outcome.
module jogador_automatico
   import jogador_pkg::*;
#(
   parameter int unsigned N_RODADAS = 16,
   parameter int unsigned T_PRESS   = 5,
   parameter int unsigned T_SOLTA   = 5,
   parameter int unsigned T_GAP     = 4,
   parameter int unsigned WATCHDOG  = 4096
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             iniciar,
   input  logic [1:0]       modo,
   input  logic [LED_W-1:0] leds,
   input  logic             ganhou,
   input  logic             perdeu,
   input  logic             timeout,
   output logic             jogar,
   output logic [1:0]       configuracao,
   output logic [LED_W-1:0] botoes,
   output logic [CNT_W-1:0] rodada,
   output logic             concluido,
   output logic             sucesso,
   output logic             falha,
   output logic             db_divergencia,
   output logic [4:0]       db_estado
);

   localparam int unsigned T_MAX_A = (T_PRESS > T_SOLTA) ? T_PRESS : T_SOLTA;
   localparam int unsigned T_MAX_B = (T_GAP > 2) ? T_GAP : 2;
   localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int unsigned T_MAX   = (WATCHDOG > T_MAX_C) ? WATCHDOG : T_MAX_C;
   localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

   localparam logic [TMR_W-1:0] LD_INICIA = TMR_W'(1);
   localparam logic [TMR_W-1:0] LD_GAP    = TMR_W'(T_GAP - 1);
   localparam logic [TMR_W-1:0] LD_PRESS  = TMR_W'(T_PRESS - 1);
   localparam logic [TMR_W-1:0] LD_SOLTA  = TMR_W'(T_SOLTA - 1);
   localparam logic [TMR_W-1:0] LD_WD     = TMR_W'(WATCHDOG - 1);
   localparam logic [CNT_W-1:0] RODADA_ULT = CNT_W'(N_RODADAS - 1);

   estado_t          state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rodada_q, rodada_d;
   logic [1:0]       conf_q, conf_d;
   logic             div_q, div_d;
   logic             aceso_q, aceso_d;
   logic             jogar_q, jogar_d;
   logic [LED_W-1:0] botoes_q, botoes_d;
   logic             concluido_q, concluido_d;
   logic             sucesso_q, sucesso_d;
   logic             falha_q, falha_d;
   logic [LED_W-1:0] mem_q [MEM_D];

   logic             mem_we;
   logic             tmr_load, tmr_done_c;
   logic [TMR_W-1:0] tmr_val;
   logic [CNT_W-1:0] lim_c;
   logic             rise_c;

   contador_timer #(.W(TMR_W)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (1'b1),
      .done_c   (tmr_done_c)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      rodada_d = rodada_q;
      conf_d   = conf_q;
      div_d    = div_q;
      aceso_d  = (leds != '0);
      mem_we   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = LD_WD;
      lim_c    = CNT_W'(rodada_q + CNT_W'(1));
      rise_c   = (leds != '0) && !aceso_q;

      case (state_q)
         OCIOSO: begin
            if (iniciar) begin
               conf_d   = modo;
               rodada_d = '0;
               cnt_d    = '0;
               idx_d    = '0;
               div_d    = 1'b0;
               state_d  = INICIA;
            end
         end
         INICIA: if (tmr_done_c) state_d = OBSERVA;
         OBSERVA: begin
            // Every LED edge restarts the watchdog; only the first rodada+1 are stored.
            if (rise_c) begin
               tmr_load = 1'b1;
               if (cnt_q < lim_c) begin
                  mem_we = 1'b1;
                  cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
                  if ((cnt_q != '0) && (cnt_q == rodada_q) && (leds != pattern(cnt_q))) begin
                     div_d = 1'b1;
                  end
               end
            end
            if ((cnt_q == lim_c) && !aceso_q) begin
               state_d = GAP;
            end else if (tmr_done_c && !rise_c) begin
               state_d = FIM_FALHA;
            end
         end
         GAP: begin
            if (tmr_done_c) begin
               idx_d   = '0;
               state_d = PRESSIONA;
            end
         end
         PRESSIONA: if (tmr_done_c) state_d = SOLTA;
         SOLTA: begin
            if (tmr_done_c) begin
               if ({1'b0, idx_q} < rodada_q) begin
                  idx_d   = IDX_W'(idx_q + IDX_W'(1));
                  state_d = PRESSIONA;
               end else if (rodada_q == RODADA_ULT) begin
                  state_d = AGUARDA_FIM;
               end else begin
                  state_d = ADICIONA;
               end
            end
         end
         ADICIONA: if (tmr_done_c) state_d = ADICIONA_SOLTA;
         ADICIONA_SOLTA: begin
            if (tmr_done_c) begin
               rodada_d = CNT_W'(rodada_q + CNT_W'(1));
               cnt_d    = '0;
               state_d  = OBSERVA;
            end
         end
         AGUARDA_FIM: if (tmr_done_c) state_d = FIM_FALHA;
         FIM_SUCESSO, FIM_FALHA: if (iniciar) state_d = OCIOSO;
         default: state_d = OCIOSO;
      endcase

      // Game verdict overrides everything; a loss beats a simultaneous win.
      if (!(state_q inside {OCIOSO, FIM_SUCESSO, FIM_FALHA})) begin
         if (perdeu || timeout) begin
            state_d = FIM_FALHA;
         end else if (ganhou) begin
            state_d = FIM_SUCESSO;
         end
      end

      if (state_d != state_q) begin
         tmr_load = 1'b1;
         case (state_d)
            INICIA:                  tmr_val = LD_INICIA;
            GAP:                     tmr_val = LD_GAP;
            PRESSIONA, ADICIONA:     tmr_val = LD_PRESS;
            SOLTA, ADICIONA_SOLTA:   tmr_val = LD_SOLTA;
            default:                 tmr_val = LD_WD;
         endcase
      end

      case (state_d)
         PRESSIONA: botoes_d = mem_q[idx_d];
         ADICIONA:  botoes_d = pattern(CNT_W'(rodada_d + CNT_W'(1)));
         default:   botoes_d = '0;
      endcase
      jogar_d     = (state_d == INICIA);
      concluido_d = (state_d == FIM_SUCESSO) || (state_d == FIM_FALHA);
      sucesso_d   = (state_d == FIM_SUCESSO);
      falha_d     = (state_d == FIM_FALHA);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= OCIOSO;
         idx_q       <= '0;
         cnt_q       <= '0;
         rodada_q    <= '0;
         conf_q      <= '0;
         div_q       <= 1'b0;
         aceso_q     <= 1'b0;
         jogar_q     <= 1'b0;
         botoes_q    <= '0;
         concluido_q <= 1'b0;
         sucesso_q   <= 1'b0;
         falha_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         rodada_q    <= rodada_d;
         conf_q      <= conf_d;
         div_q       <= div_d;
         aceso_q     <= aceso_d;
         jogar_q     <= jogar_d;
         botoes_q    <= botoes_d;
         concluido_q <= concluido_d;
         sucesso_q   <= sucesso_d;
         falha_q     <= falha_d;
      end
   end

   // Captured sequence; contents are meaningless until written in OBSERVA.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[cnt_q[IDX_W-1:0]] <= leds;
      end
   end

   assign jogar          = jogar_q;
   assign configuracao   = conf_q;
   assign botoes         = botoes_q;
   assign rodada         = rodada_q;
   assign concluido      = concluido_q;
   assign sucesso        = sucesso_q;
   assign falha          = falha_q;
   assign db_divergencia = div_q;
   assign db_estado      = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a behavioural game model plays full and
// aborted games against a 16-round player and a 1-round player.
module tb_jogador_automatico;

   localparam int unsigned T_PRESS  = 5;
   localparam int unsigned T_SOLTA  = 5;
   localparam int unsigned T_GAP    = 4;
   localparam int unsigned WATCHDOG = 4096;
   localparam int unsigned N_A      = 16;

   logic       clock, reset;
   logic       iniciar_a, ganhou_a, perdeu_a, timeout_a;
   logic [1:0] modo_a, configuracao_a;
   logic [3:0] leds_a, botoes_a;
   logic [4:0] rodada_a, db_estado_a;
   logic       jogar_a, concluido_a, sucesso_a, falha_a, db_div_a;

   logic       iniciar_b, ganhou_b, perdeu_b, timeout_b;
   logic [1:0] modo_b, configuracao_b;
   logic [3:0] leds_b, botoes_b;
   logic [4:0] rodada_b, db_estado_b;
   logic       jogar_b, concluido_b, sucesso_b, falha_b, db_div_b;

   int         cmp_n = 0;
   int         err_n = 0;
   int         presses, adds;
   logic [3:0] seq [16];

   jogador_automatico #(.N_RODADAS(N_A), .T_PRESS(T_PRESS), .T_SOLTA(T_SOLTA),
                        .T_GAP(T_GAP), .WATCHDOG(WATCHDOG)) dut_a (
      .clock(clock), .reset(reset), .iniciar(iniciar_a), .modo(modo_a), .leds(leds_a),
      .ganhou(ganhou_a), .perdeu(perdeu_a), .timeout(timeout_a), .jogar(jogar_a),
      .configuracao(configuracao_a), .botoes(botoes_a), .rodada(rodada_a),
      .concluido(concluido_a), .sucesso(sucesso_a), .falha(falha_a),
      .db_divergencia(db_div_a), .db_estado(db_estado_a));

   jogador_automatico #(.N_RODADAS(1), .T_PRESS(T_PRESS), .T_SOLTA(T_SOLTA),
                        .T_GAP(T_GAP), .WATCHDOG(WATCHDOG)) dut_b (
      .clock(clock), .reset(reset), .iniciar(iniciar_b), .modo(modo_b), .leds(leds_b),
      .ganhou(ganhou_b), .perdeu(perdeu_b), .timeout(timeout_b), .jogar(jogar_b),
      .configuracao(configuracao_b), .botoes(botoes_b), .rodada(rodada_b),
      .concluido(concluido_b), .sucesso(sucesso_b), .falha(falha_b),
      .db_divergencia(db_div_b), .db_estado(db_estado_b));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_n++;
      assert (obs === exp) else begin
         err_n++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic wait_press_start(output logic [3:0] v, output bit ok);
      ok = 1'b0;
      v  = 4'd0;
      for (int k = 0; k < 200 && !ok; k++) begin
         tick();
         if (botoes_a != 4'd0) begin
            ok = 1'b1;
            v  = botoes_a;
         end
      end
   endtask

   task automatic get_press(output logic [3:0] v);
      bit ok;
      bit held;
      int len;
      wait_press_start(v, ok);
      check("press_seen", 32'(ok), 32'd1);
      len  = 1;
      held = ok;
      for (int k = 0; k < 50 && held; k++) begin
         tick();
         if (botoes_a == v) len++;
         else held = 1'b0;
      end
      check("press_len", 32'(len), 32'(T_PRESS));
   endtask

   task automatic show_round(input int r, input int inj_idx, input logic [3:0] inj_val);
      repeat (T_SOLTA + 2) tick();
      check("rodada", 32'(rodada_a), 32'(r));
      check("estado_observa", 32'(db_estado_a), 32'd2);
      for (int i = 0; i <= r; i++) begin
         leds_a = (i == inj_idx) ? inj_val : seq[i];
         repeat ($urandom_range(2, 5)) tick();
         leds_a = 4'd0;
         repeat ($urandom_range(2, 4)) tick();
      end
   endtask

   task automatic run_rounds(input int first, input int last);
      logic [3:0] v;
      logic [3:0] pat;
      for (int r = first; r <= last; r++) begin
         show_round(r, -1, 4'd0);
         for (int i = 0; i <= r; i++) begin
            get_press(v);
            check("replay", 32'(v), 32'(seq[i]));
            presses++;
         end
         if (r < int'(N_A) - 1) begin
            get_press(v);
            pat = 4'b0001;
            pat = pat << ((r + 1) % 4);
            check("addition", 32'(v), 32'(pat));
            seq[r+1] = v;
            adds++;
         end
      end
   endtask

   task automatic start_a(input logic [1:0] m);
      int jog;
      modo_a    = m;
      iniciar_a = 1'b1;
      tick();
      iniciar_a = 1'b0;
      modo_a    = ~m;
      jog = 0;
      for (int k = 0; k < 5; k++) begin
         if (jogar_a) jog++;
         tick();
      end
      check("jogar_cycles", 32'(jog), 32'd2);
      check("configuracao", 32'(configuracao_a), 32'(m));
      check("rodada_start", 32'(rodada_a), 32'd0);
      check("div_start", 32'(db_div_a), 32'd0);
   endtask

   task automatic to_ocioso();
      iniciar_a = 1'b1;
      tick();
      iniciar_a = 1'b0;
      check("back_to_ocioso", 32'(db_estado_a), 32'd0);
   endtask

   initial begin
      logic [3:0] v;
      logic [3:0] lb;
      bit         ok;
      int         cyc, jog, nz;

      reset = 1'b1;
      {iniciar_a, ganhou_a, perdeu_a, timeout_a, modo_a, leds_a} = '0;
      {iniciar_b, ganhou_b, perdeu_b, timeout_b, modo_b, leds_b} = '0;
      seq[0] = 4'b0001;
      repeat (3) tick();
      check("rst_jogar", 32'(jogar_a), 32'd0);
      check("rst_botoes", 32'(botoes_a), 32'd0);
      check("rst_estado", 32'(db_estado_a), 32'd0);
      check("rst_flags", 32'({concluido_a, sucesso_a, falha_a, db_div_a}), 32'd0);
      check("rst_rodada_conf", 32'({rodada_a, configuracao_a}), 32'd0);
      check("rst_b", 32'({jogar_b, botoes_b, db_estado_b, concluido_b}), 32'd0);
      reset = 1'b0;
      tick();

      // Full 16-round game ending in a win.
      presses = 0;
      adds    = 0;
      start_a(2'b00);
      run_rounds(0, 15);
      repeat (T_SOLTA + 2) tick();
      check("estado_aguarda", 32'(db_estado_a), 32'd8);
      ganhou_a = 1'b1;
      tick();
      ganhou_a = 1'b0;
      check("win_sucesso", 32'(sucesso_a), 32'd1);
      check("win_concluido", 32'(concluido_a), 32'd1);
      check("win_falha", 32'(falha_a), 32'd0);
      check("win_estado", 32'(db_estado_a), 32'd9);
      check("win_div", 32'(db_div_a), 32'd0);
      check("win_presses", 32'(presses), 32'd136);
      check("win_adds", 32'(adds), 32'd15);

      // Corrupted LED at index 3 of round 3, replayed as seen, game declares loss.
      to_ocioso();
      start_a(2'($urandom_range(0, 3)));
      run_rounds(0, 2);
      show_round(3, 3, 4'b0001);
      check("inject_div", 32'(db_div_a), 32'd1);
      for (int i = 0; i < 3; i++) begin
         get_press(v);
         check("inject_prefix", 32'(v), 32'(seq[i]));
      end
      wait_press_start(v, ok);
      check("inject_seen", 32'(ok), 32'd1);
      check("inject_replay", 32'(v), 32'b0001);
      perdeu_a = (v != seq[3]);
      tick();
      perdeu_a = 1'b0;
      check("loss_falha", 32'(falha_a), 32'd1);
      check("loss_estado", 32'(db_estado_a), 32'd10);
      check("loss_botoes", 32'(botoes_a), 32'd0);
      check("loss_div_sticky", 32'(db_div_a), 32'd1);

      // Timeout during a replay press at round 5.
      to_ocioso();
      start_a(2'($urandom_range(0, 3)));
      run_rounds(0, 4);
      show_round(5, -1, 4'd0);
      wait_press_start(v, ok);
      check("to_pressiona", 32'(db_estado_a), 32'd4);
      check("to_rodada", 32'(rodada_a), 32'd5);
      check("to_press_val", 32'(v), 32'(seq[0]));
      timeout_a = 1'b1;
      tick();
      timeout_a = 1'b0;
      check("to_estado", 32'(db_estado_a), 32'd10);
      check("to_botoes", 32'(botoes_a), 32'd0);
      check("to_falha", 32'(falha_a), 32'd1);

      // Game never shows an LED: watchdog aborts.
      to_ocioso();
      start_a(2'($urandom_range(0, 3)));
      cyc = 0;
      while (!falha_a && cyc < int'(WATCHDOG) + 100) begin
         tick();
         cyc++;
      end
      check("wd_window", 32'(cyc >= int'(WATCHDOG) - 8 && cyc <= int'(WATCHDOG) + 2), 32'd1);
      check("wd_estado", 32'(db_estado_a), 32'd10);

      // Asynchronous reset in the middle of an addition press.
      to_ocioso();
      start_a(2'($urandom_range(0, 3)));
      show_round(0, -1, 4'd0);
      get_press(v);
      check("rst_replay", 32'(v), 32'(seq[0]));
      wait_press_start(v, ok);
      check("rst_adiciona", 32'(db_estado_a), 32'd6);
      check("rst_add_val", 32'(v), 32'b0010);
      #2 reset = 1'b1;
      #1;
      check("rst_async_botoes", 32'(botoes_a), 32'd0);
      check("rst_async_jogar", 32'(jogar_a), 32'd0);
      check("rst_async_estado", 32'(db_estado_a), 32'd0);
      #39 reset = 1'b0;
      tick();
      check("rst_after_rodada", 32'(rodada_a), 32'd0);
      start_a(2'($urandom_range(0, 3)));
      check("rst_restart_estado", 32'(db_estado_a), 32'd2);

      // Single-round player: one LED, one press, no addition, loss beats win.
      modo_b    = 2'($urandom_range(0, 3));
      iniciar_b = 1'b1;
      tick();
      iniciar_b = 1'b0;
      jog = 0;
      for (int k = 0; k < 5; k++) begin
         if (jogar_b) jog++;
         tick();
      end
      check("b_jogar_cycles", 32'(jog), 32'd2);
      lb = 4'b0001;
      lb = lb << $urandom_range(0, 3);
      leds_b = lb;
      repeat (3) tick();
      leds_b = 4'd0;
      repeat (3) tick();
      ok = 1'b0;
      v  = 4'd0;
      for (int k = 0; k < 100 && !ok; k++) begin
         tick();
         if (botoes_b != 4'd0) begin
            ok = 1'b1;
            v  = botoes_b;
         end
      end
      check("b_press_seen", 32'(ok), 32'd1);
      check("b_press_val", 32'(v), 32'(lb));
      nz = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (botoes_b != 4'd0) nz++;
      end
      check("b_no_addition", 32'(nz), 32'(T_PRESS - 1));
      check("b_aguarda", 32'(db_estado_b), 32'd8);
      ganhou_b = 1'b1;
      perdeu_b = 1'b1;
      tick();
      ganhou_b = 1'b0;
      perdeu_b = 1'b0;
      check("b_falha", 32'(falha_b), 32'd1);
      check("b_sucesso", 32'(sucesso_b), 32'd0);
      check("b_estado", 32'(db_estado_b), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
